// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station scheduler: lowest-free-entry allocation, age-matrix
// oldest-ready-first grant, and a one-deep issue-stage register.
module alu_rs_scheduler #(
    parameter int ENTRIES = 4,
    parameter int IDX     = 1
) (
    input  logic               clk,
    input  logic               globalReset,
    input  logic               dispatchValid,
    output logic               rsFull,
    output logic [ENTRIES-1:0] writeReq,
    input  logic [ENTRIES-1:0] busy,
    input  logic [ENTRIES-1:0] selectReq,
    output logic [ENTRIES-1:0] selected,
    output logic               execute,
    input  logic               aluReady,
    output logic               issueValid,
    output logic [IDX:0]       issueIdx,
    input  logic               clear,
    input  logic               validCommit
);
    localparam int IW = IDX + 1;

    logic                            flush;
    logic                            alloc_done;
    logic                            grant_done;
    logic [ENTRIES-1:0]              req;
    logic [ENTRIES-1:0]              blocked;
    logic [ENTRIES-1:0]              cand;
    logic [IW-1:0]                   sel_idx;
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q;
    logic [ENTRIES-1:0][ENTRIES-1:0] older_d;
    logic                            issue_valid_q;
    logic                            issue_valid_d;
    logic [IW-1:0]                   issue_idx_q;
    logic [IW-1:0]                   issue_idx_d;

    // Handshake: the issue register accepts a grant (execute) when it is empty or
    // the ALU takes its current instruction (aluReady); a stalled stage holds.
    assign flush      = clear & validCommit;
    assign rsFull     = &busy;
    assign execute    = globalReset & ~flush & (~issue_valid_q | aluReady);
    assign issueValid = issue_valid_q;
    assign issueIdx   = issue_idx_q;

    always_comb begin
        writeReq   = '0;
        alloc_done = 1'b0;
        if (globalReset && dispatchValid && !rsFull && !flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (!busy[i] && !alloc_done) begin
                    writeReq[i] = 1'b1;
                    alloc_done  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req     = selectReq & busy & ~writeReq;
        blocked = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && req[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        cand = req & ~blocked & {ENTRIES{execute}};
        // Lowest index breaks ties the age matrix cannot order (e.g. after a flush).
        selected   = '0;
        sel_idx    = '0;
        grant_done = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (cand[i] && !grant_done) begin
                selected[i] = 1'b1;
                sel_idx     = IW'(i);
                grant_done  = 1'b1;
            end
        end
    end

    always_comb begin
        older_d       = older_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        if (flush) begin
            older_d       = '0;
            issue_valid_d = 1'b0;
            issue_idx_d   = '0;
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (writeReq[k]) begin
                    for (int j = 0; j < ENTRIES; j++) begin
                        older_d[k][j] = 1'b0;
                        if (j != k) begin
                            older_d[j][k] = busy[j];
                        end
                    end
                end
            end
            if (execute) begin
                issue_valid_d = |selected;
                issue_idx_d   = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            older_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else begin
            older_q       <= older_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
        end
    end
endmodule

// File: doc/alu_rs_scheduler.md
ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 Parameter ENTRIES, default 4, number of ALU reservation-station entries managed (power of two, 2..8).
REQ-002 Parameter IDX, default 1, entry index width minus one (IDX+1 = log2(ENTRIES)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 globalReset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-005 dispatchValid  input  1  decode stage presents an ALU instruction for allocation this cycle.
REQ-006 rsFull  output  1  no free entry; dispatch stalls.
REQ-007 writeReq  output  ENTRIES  one-hot write strobe to the allocated entry.
REQ-008 busy  input  ENTRIES  per-entry busy flags.
REQ-009 selectReq  input  ENTRIES  per-entry operand-ready requests.
REQ-010 selected  output  ENTRIES  one-hot grant to the chosen entry.
REQ-011 execute  output  1  issue stage can accept, so the granted entry frees itself.
REQ-012 aluReady  input  1  ALU consumes the issue-stage instruction this cycle.
REQ-013 issueValid  output  1  issue-stage register holds a valid instruction.
REQ-014 issueIdx  output  IDX+1  entry index held in the issue stage, for the operand/control mux.
REQ-015 clear, validCommit  input  1 each  flush request; effective only when both are 1.

Function
REQ-016 Allocation: writeReq SHALL be one-hot on the lowest-index entry with busy=0 when dispatchValid=1, rsFull=0 and no flush; all zero otherwise.
REQ-017 rsFull SHALL equal AND of busy (combinational).
REQ-018 Effective request: req[i] = selectReq[i] AND busy[i]; an entry written this cycle SHALL NOT be granted this cycle.
REQ-019 Age matrix: ENTRIES x ENTRIES bits, older[i][j]=1 means entry i allocated before entry j; diagonal unused.
REQ-020 On allocation of entry k: older[k][j] <= 0 for all j; older[j][k] <= busy[j] for all j != k.
REQ-021 Grant: selected[i]=1 iff req[i]=1, execute=1, and no j with req[j]=1 and older[j][i]=1 (oldest-ready-first); at most one bit set.
REQ-022 execute = (issueValid=0) OR (aluReady=1), forced 0 during flush.
REQ-023 Issue stage: when execute=1, issueValid <= OR(selected), issueIdx <= index of selected bit; when execute=0, hold both.
REQ-024 Latency: grant in cycle N -> issueValid=1 in cycle N+1; back-to-back issue every cycle when aluReady=1.
REQ-025 Stall: issueValid=1 with aluReady=0 SHALL hold issueIdx unchanged and selected SHALL be all zero.
REQ-026 Flush (clear & validCommit): writeReq and selected all zero that cycle; next edge issueValid <= 0, issueIdx <= 0, age matrix <= 0.
REQ-027 Simultaneous allocate and grant in one cycle SHALL both proceed (different entries guaranteed by REQ-018).
REQ-028 An entry freed by grant in cycle N SHALL be allocatable from cycle N+1 (follows busy).

Reset
REQ-029 globalReset=0 SHALL asynchronously set issueValid=0, issueIdx=0, age matrix all 0.
REQ-030 During reset writeReq, selected and execute SHALL be 0; rsFull follows busy.
REQ-031 Release of reset SHALL take effect at the next rising clk with no spurious grant.

Verification
REQ-032 Empty RS, dispatchValid=1 four consecutive cycles -> writeReq 0001,0010,0100,1000; rsFull=1 after busy=1111; fifth dispatch -> writeReq=0000.
REQ-033 Allocate order 2,0,3 then selectReq=1101 all busy -> selected=0100 (entry 2), next cycle entry 0, then entry 3.
REQ-034 issueValid=1, aluReady=0 for 3 cycles with req=0011 -> execute=0, selected=0000, issueIdx held; aluReady=1 -> oldest granted same cycle.
REQ-035 Entry 1 not busy, selectReq=0010, writeReq=0010 same cycle -> selected=0000; granted next cycle.
REQ-036 clear=1, validCommit=1 with issueValid=1, dispatchValid=1 -> writeReq=0000, selected=0000; next cycle issueValid=0.
REQ-037 globalReset driven 0 mid-cycle while issueValid=1 -> issueValid=0 immediately, before next clk edge.
